// File: rtl/aes_pkg.sv
// Shared AES-128 definitions used by the key expansion and the reverse
// key schedule: key/round counts, the S-box and the round-constant table.
// No ports; import with "import aes_pkg::*;".
package aes_pkg;

    localparam int NK = 4;
    localparam int NR = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ks_state_t;

    // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse (a^254, which maps 0 to 0)
    // followed by the FIPS-197 affine transform.
    function automatic logic [7:0] aes_sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] base;
        logic [7:0] e;
        inv  = 8'h01;
        base = a;
        e    = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) begin
                inv = gf_mul(inv, base);
            end else begin
                inv = inv;
            end
            base = gf_mul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant for rounds 1..10 (top byte only); anything else is 0.
    function automatic logic [7:0] aes_rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel combinational S-box lookups on a 32-bit word.
// Ports: word (32-bit input), sub (32-bit substituted output).
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub = {aes_sbox(word[31:24]), aes_sbox(word[23:16]),
                  aes_sbox(word[15:8]),  aes_sbox(word[7:0])};

endmodule

// File: rtl/inv_key_schedule.sv
// Reverse AES-128 key schedule: starting from the round-10 key, emits the
// round keys 10 down to 0, one per accepted beat, recomputing each previous
// round key on the fly from the current one.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, last_key request and round-10 key (word 0 in [127:96])
//   rk_ready        consumer accepts the current beat
//   rk_valid, rk, rk_round  current round key and its round index
//   busy            schedule in progress
//   done            one-cycle pulse after the round-0 beat is accepted
module inv_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    ks_state_t    state_r;
    logic [31:0]  w0_s;
    logic [31:0]  w1_s;
    logic [31:0]  w2_s;
    logic [31:0]  w3_s;
    logic [31:0]  p0_s;
    logic [31:0]  p1_s;
    logic [31:0]  p2_s;
    logic [31:0]  p3_s;
    logic [31:0]  rot_s;
    logic [31:0]  sub_s;
    logic [127:0] prev_rk_s;

    // Only p3 goes through the S-box; it equals w[4i-1] of the previous round.
    aes_subword u_subword (
        .word (rot_s),
        .sub  (sub_s)
    );

    // InvStep: undo one round of the forward expansion.
    always_comb begin
        w0_s      = rk[127:96];
        w1_s      = rk[95:64];
        w2_s      = rk[63:32];
        w3_s      = rk[31:0];
        p3_s      = w3_s ^ w2_s;
        p2_s      = w2_s ^ w1_s;
        p1_s      = w1_s ^ w0_s;
        rot_s     = {p3_s[23:0], p3_s[31:24]};
        p0_s      = w0_s ^ sub_s ^ {aes_rcon(rk_round), 24'h000000};
        prev_rk_s = {p0_s, p1_s, p2_s, p3_s};
    end

    // Control FSM and round-key register; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rk       <= 128'h0;
            rk_round <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rk       <= last_key;
                        rk_round <= 4'd10;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                        state_r  <= ST_EMIT;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    done <= 1'b0;
                    if (rk_valid && rk_ready) begin
                        if (rk_round == 4'd0) begin
                            // rk/rk_round deliberately keep their last values.
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state_r  <= ST_IDLE;
                        end else begin
                            rk       <= prev_rk_s;
                            rk_round <= rk_round - 4'd1;
                        end
                    end else begin
                        // Stall: everything holds.
                        state_r <= ST_EMIT;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    rk_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule: a forward key expansion model
// produces the expected round keys, which are queued at start and consumed
// by an independent monitor on each accepted beat.
module tb_inv_key_schedule;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] last_key;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [131:0] exp_q[$];
    logic [127:0] model_rk [0:10];
    logic         chk_zero   = 1'b1;
    logic         done_exp   = 1'b0;
    logic         ready_rand = 1'b0;

    inv_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .last_key (last_key),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk       (rk),
        .rk_round (rk_round),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Forward AES-128 key expansion: model_rk[r] holds round key r.
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0)
                t = {aes_sbox(t[23:16]), aes_sbox(t[15:8]), aes_sbox(t[7:0]), aes_sbox(t[31:24])}
                    ^ {aes_rcon(4'(i / 4)), 24'h000000};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_all();
        for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), model_rk[r]});
    endtask

    // Issue an accepted start (called when the DUT is idle).
    task automatic issue();
        start    = 1'b1;
        last_key = model_rk[10];
        step();
        start = 1'b0;
        push_all();
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d beats still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        step();
    endtask

    task automatic wait_round(input logic [3:0] r, input int max_cycles);
        int n = 0;
        while (!(rk_valid && rk_round == r) && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (!(rk_valid && rk_round == r)) begin
            failures++;
            $display("FAIL wait_round: round %0d never presented (valid=%0b round=%0d)", r, rk_valid, rk_round);
        end
    endtask

    task automatic rand_key(output logic [127:0] k);
        k = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Ready driver: random or held high.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rk_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor/scoreboard.
    always @(negedge clk) begin
        logic last_acc;
        last_acc = 1'b0;
        if (chk_zero) begin
            checks++;
            if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk !== 128'h0 || rk_round !== 4'd0) begin
                failures++;
                $display("FAIL reset_state: valid=%0b busy=%0b done=%0b rk=%h round=%0d, required all zero",
                         rk_valid, busy, done, rk, rk_round);
            end
            chk_zero = 1'b0;
        end else begin
            checks++;
            if (done !== done_exp) begin
                failures++;
                $display("FAIL done: got %0b, required %0b", done, done_exp);
            end
            checks++;
            if (rk_valid !== (exp_q.size() != 0) || busy !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL valid_busy: valid=%0b busy=%0b, required %0b", rk_valid, busy, exp_q.size() != 0);
            end
            if (rk_valid === 1'b1 && exp_q.size() != 0) begin
                checks++;
                if ({rk_round, rk} !== exp_q[0]) begin
                    failures++;
                    $display("FAIL round_key: got round %0d key %h, required round %0d key %h",
                             rk_round, rk, exp_q[0][131:128], exp_q[0][127:0]);
                end
                if (rk_ready === 1'b1) begin
                    last_acc = (exp_q[0][131:128] == 4'd0);
                    void'(exp_q.pop_front());
                end
            end
        end
        done_exp = last_acc && !rst;
        if (rst) begin
            exp_q.delete();
            chk_zero = 1'b1;
            done_exp = 1'b0;
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k;
        // Reset with start and rk_ready asserted: reset must dominate.
        rst      = 1'b1;
        start    = 1'b1;
        rk_ready = 1'b1;
        rand_key(k);
        last_key = k;
        repeat (3) step();
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) step();

        // FIPS-197 vector, ready held high.
        ready_rand = 1'b0;
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        model_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        model_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        model_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        model_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        issue();
        wait_idle(40);

        // Random keys with random back-pressure and an ignored mid-run start.
        ready_rand = 1'b1;
        for (int n = 0; n < 4; n++) begin
            rand_key(k);
            expand(k);
            issue();
            repeat (3) step();
            start = 1'b1;
            rand_key(k);
            last_key = k;
            step();
            start = 1'b0;
            wait_idle(300);
        end

        // Start on the final-beat cycle (ignored), then in the done cycle (honoured).
        ready_rand = 1'b0;
        step();
        rand_key(k);
        expand(k);
        issue();
        wait_round(4'd0, 40);
        start = 1'b1;
        rand_key(k);
        last_key = k;
        step();
        rand_key(k);
        expand(k);
        last_key = model_rk[10];
        step();
        start = 1'b0;
        push_all();
        wait_idle(40);

        // Reset after the round-6 beat, then a full clean schedule.
        rand_key(k);
        expand(k);
        issue();
        wait_round(4'd5, 40);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        ready_rand = 1'b1;
        rand_key(k);
        expand(k);
        issue();
        wait_idle(300);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 The block SHALL have no parameters; AES-128 only (NK=4, NR=10, fixed).
REQ-002 clk  input  1  single clock; all logic on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin a reverse schedule; sampled only in IDLE.
REQ-005 last_key  input  128  round-10 key, word 0 in bits [127:96], word 3 in bits [31:0]; sampled when start is accepted.
REQ-006 rk_ready  input  1  consumer accepts rk this cycle.
REQ-007 rk_valid  output  1  rk/rk_round hold a valid round key.
REQ-008 rk  output  128  current round key, same word order as last_key.
REQ-009 rk_round  output  4  round index of rk, from 10 down to 0.
REQ-010 busy  output  1  high from the cycle after start is accepted until the round-0 beat is accepted.
REQ-011 done  output  1  one-cycle pulse in the cycle after the round-0 beat is accepted.

Function
REQ-012 FSM states SHALL be IDLE and EMIT only.
REQ-013 IDLE with start=1: load last_key into rk and 10 into rk_round, go to EMIT; rk_valid=1 and busy=1 from the next cycle; latency start-to-first-valid is exactly 1 cycle.
REQ-014 EMIT with rk_valid and rk_ready both high and rk_round>0: next cycle rk = InvStep(rk, rk_round) and rk_round decrements by 1.
REQ-015 InvStep(w0..w3, i): p3=w3^w2; p2=w2^w1; p1=w1^w0; p0=w0^SubWord(RotWord(p3))^Rcon(i). RotWord maps {a0,a1,a2,a3} to {a1,a2,a3,a0}. Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 in the top byte; the lower three bytes are zero.
REQ-016 EMIT with rk_valid=0 or rk_ready=0 (a stall): rk, rk_round and rk_valid SHALL hold unchanged; there is no stall limit.
REQ-017 EMIT with rk_round=0 and rk_ready=1: next cycle go to IDLE with rk_valid=0, busy=0 and done=1 for one cycle; rk and rk_round SHALL keep their last values.
REQ-018 With rk_ready held at 1, all 11 beats (rounds 10..0) SHALL be accepted in 11 consecutive cycles; throughput is 1 round key per cycle.
REQ-019 start SHALL be ignored while in EMIT, including on the cycle the final beat is accepted; a new start is honoured from the IDLE cycle onward, including the cycle done=1.
REQ-020 rk_valid SHALL never deassert in EMIT until the round-0 beat is accepted.
REQ-021 All XORs SHALL be 32-bit and bytewise; there are no carries and no width extension.

Reset
REQ-022 When rst=1 at a clock edge: state=IDLE, rk_valid=0, busy=0, done=0, rk=0, rk_round=0.
REQ-023 rst SHALL dominate start and rk_ready in the same cycle.
REQ-024 Reset mid-schedule SHALL abort the schedule without a done pulse; the first start after reset SHALL behave exactly as in REQ-013.

Structure
REQ-025 The shared package aes_pkg SHALL hold NK, NR, the S-box function and the Rcon table; keyExpansion and this block SHALL use the same definitions.
REQ-026 One sub-module, aes_subword (four parallel combinational S-box lookups on a 32-bit word), SHALL be instantiated once for p3.
REQ-027 The datapath SHALL be one 128-bit register, one 4-bit counter and a 1-bit state; no RAM and no storage of all round keys.

Verification
REQ-028 FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c: start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 and rk_ready=1 -> round 10 key next cycle; round 9 = ac7766f319fadc2128d12941575c006e; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = 2b7e151628aed2a6abf7158809cf4f3c; done pulses 12 cycles after start.
REQ-029 Cross-check: random keys fed to keyExpansion, its round-10 slice applied as last_key -> all 11 rk beats match keyExpansion's w slices in reverse order.
REQ-030 rk_ready random ~50% -> rk and rk_round stable during every stall; still exactly 11 beats, in order 10..0.
REQ-031 start pulsed in EMIT (mid-schedule and on the final-beat cycle) -> ignored; start in the done cycle -> new schedule begins with round 10 on the next cycle.
REQ-032 rst asserted after the round-6 beat -> next cycle all outputs 0 and no done pulse; a following start produces a correct full sequence.
